mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 120 ++++++++++++
 tb/tb_mod_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Modulo-MODULUS up/down counter with synchronous clear and
//               clamped load, optional saturation at the range ends (SAT),
//               one-cycle carry/borrow pulses and an optional sticky
//               range-event flag.
//               Optional feature macro: MOD_COUNTER_STICKY_OVF_EN
//                 defined   -> ovf is a sticky register set by carry/borrow
//                 undefined -> ovf is tied to 0 (port list unchanged)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int N       = 4,   // counter width in bits (N >= 1)
    parameter int MODULUS = 8,   // count range 0..MODULUS-1 (2 <= MODULUS <= 2^N)
    parameter int SAT     = 0    // 0 = wrap at range ends, 1 = saturate
) (
    input  logic         clk,
    input  logic         reset,       // asynchronous, active-low
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] data,
    input  logic         count_up,
    input  logic         count_down,
    output logic [N-1:0] value,
    output logic         zero,
    output logic         max,
    output logic         msb,
    output logic         carry,
    output logic         borrow,
    output logic         ovf
);

    // Range limit held at N+1 bits so MODULUS = 2^N is representable.
    localparam logic [N:0]   LIMIT    = (N+1)'(MODULUS);
    localparam logic [N-1:0] LAST_VAL = N'(MODULUS - 1);

    logic [N:0]   inc_ext;      // value + 1, with carry-out bit
    logic [N:0]   dec_ext;      // value - 1, top bit flags underflow
    logic [N-1:0] load_val;     // data clamped into range
    logic         up_only;
    logic         down_only;
    logic [N-1:0] value_nxt;
    logic         carry_nxt;
    logic         borrow_nxt;

    assign inc_ext   = {1'b0, value} + (N+1)'(1);
    assign dec_ext   = {1'b0, value} - (N+1)'(1);
    assign load_val  = ({1'b0, data} < LIMIT) ? data : LAST_VAL;
    assign up_only   = count_up & ~count_down;
    assign down_only = count_down & ~count_up;

    // Next-state selection: clr beats load, load beats counting.
    always_comb begin
        value_nxt  = value;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (clr) begin
            value_nxt = '0;
        end else if (load) begin
            value_nxt = load_val;
        end else if (up_only) begin
            if (inc_ext == LIMIT) begin
                // Top of range: wrap to 0 or hold, and flag it either way.
                carry_nxt = 1'b1;
                value_nxt = (SAT != 0) ? value : '0;
            end else begin
                value_nxt = inc_ext[N-1:0];
            end
        end else if (down_only) begin
            if (dec_ext[N]) begin
                // Bottom of range (0 - 1 underflowed): wrap or hold.
                borrow_nxt = 1'b1;
                value_nxt  = (SAT != 0) ? value : LAST_VAL;
            end else begin
                value_nxt = dec_ext[N-1:0];
            end
        end
    end

    // Count register plus the one-cycle carry/borrow pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            value  <= value_nxt;
            carry  <= carry_nxt;
            borrow <= borrow_nxt;
        end
    end

`ifdef MOD_COUNTER_STICKY_OVF_EN
    logic ovf_q;

    // Sticky flag: picks up a pulse one cycle after it appears; only clr
    // or reset clear it, a load leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | carry | borrow;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Status decodes straight from the registered count.
    assign zero = (value == '0);
    assign max  = (value == LAST_VAL);
    assign msb  = value[N-1];

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter
// Description : Self-checking bench for mod_counter. Four instances with
//               different parameter sets share one stimulus stream; a
//               behavioural model per instance pushes expected outputs into
//               a scoreboard queue that is drained after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic [3:0] data;
    logic       count_up;
    logic       count_down;

    // Instance outputs: A (4,10,wrap) B (4,10,sat) C (3,8,wrap) D (4,16,wrap)
    logic [3:0] v_a, v_b, v_d;
    logic [2:0] v_c;
    logic [3:0] z, mx, ms, cy, bw, of;

    mod_counter #(.N(4), .MODULUS(10), .SAT(0)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data),
        .count_up(count_up), .count_down(count_down), .value(v_a),
        .zero(z[0]), .max(mx[0]), .msb(ms[0]), .carry(cy[0]), .borrow(bw[0]), .ovf(of[0]));
    mod_counter #(.N(4), .MODULUS(10), .SAT(1)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data),
        .count_up(count_up), .count_down(count_down), .value(v_b),
        .zero(z[1]), .max(mx[1]), .msb(ms[1]), .carry(cy[1]), .borrow(bw[1]), .ovf(of[1]));
    mod_counter #(.N(3), .MODULUS(8), .SAT(0)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data[2:0]),
        .count_up(count_up), .count_down(count_down), .value(v_c),
        .zero(z[2]), .max(mx[2]), .msb(ms[2]), .carry(cy[2]), .borrow(bw[2]), .ovf(of[2]));
    mod_counter #(.N(4), .MODULUS(16), .SAT(0)) u_d (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data),
        .count_up(count_up), .count_down(count_down), .value(v_d),
        .zero(z[3]), .max(mx[3]), .msb(ms[3]), .carry(cy[3]), .borrow(bw[3]), .ovf(of[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned v;
        bit          c;
        bit          b;
        bit          o;
    } mstate_t;

    typedef struct {
        int         id;
        logic [9:0] exp;
        string      tag;
    } sb_entry_t;

    mstate_t     mdl [4];
    int unsigned mods [4] = '{10, 10, 8, 16};
    bit          sats [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int unsigned wid  [4] = '{4, 4, 3, 4};
    sb_entry_t   sbq [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference behaviour of one counter for one clock edge.
    function automatic mstate_t model_next(mstate_t s, int unsigned m, bit sat,
                                           bit c_i, bit l_i, int unsigned d,
                                           bit u_i, bit dn_i);
        mstate_t n;
`ifdef MOD_COUNTER_STICKY_OVF_EN
        n.o = c_i ? 1'b0 : (s.o | s.c | s.b);
`else
        n.o = 1'b0;
`endif
        n.c = 1'b0;
        n.b = 1'b0;
        n.v = s.v;
        if (c_i) begin
            n.v = 0;
        end else if (l_i) begin
            n.v = (d < m) ? d : m - 1;
        end else if (u_i && !dn_i) begin
            if (s.v == m - 1) begin
                n.c = 1'b1;
                n.v = sat ? s.v : 0;
            end else begin
                n.v = s.v + 1;
            end
        end else if (dn_i && !u_i) begin
            if (s.v == 0) begin
                n.b = 1'b1;
                n.v = sat ? 0 : m - 1;
            end else begin
                n.v = s.v - 1;
            end
        end
        return n;
    endfunction

    // Expected output vector {value, carry, borrow, ovf, zero, max, msb}.
    function automatic logic [9:0] pack_exp(int id);
        mstate_t s;
        bit      top;
        s   = mdl[id];
        top = ((s.v >> (wid[id] - 1)) & 1) != 0;
        return {4'(s.v), s.c, s.b, s.o, (s.v == 0), (s.v == mods[id] - 1), top};
    endfunction

    function automatic logic [9:0] obs(int id);
        logic [3:0] v;
        case (id)
            0:       v = v_a;
            1:       v = v_b;
            2:       v = {1'b0, v_c};
            default: v = v_d;
        endcase
        return {v, cy[id], bw[id], of[id], z[id], mx[id], ms[id]};
    endfunction

    task automatic push_all(input string tag);
        for (int i = 0; i < 4; i++) sbq.push_back('{i, pack_exp(i), tag});
    endtask

    task automatic drain();
        sb_entry_t  e;
        logic [9:0] got;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            got = obs(e.id);
            n_cmp++;
            assert (got === e.exp) else begin
                n_bad++;
                $error("FAIL %s dut%0d observed=%h expected=%h", e.tag, e.id, got, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clocked step: drive inputs, predict, clock, compare.
    task automatic step(input string tag, input bit c_i, input bit l_i,
                        input logic [3:0] d, input bit u_i, input bit dn_i);
        clr        = c_i;
        load       = l_i;
        data       = d;
        count_up   = u_i;
        count_down = dn_i;
        for (int i = 0; i < 4; i++)
            mdl[i] = model_next(mdl[i], mods[i], sats[i], c_i, l_i,
                                (i == 2) ? 32'(d[2:0]) : 32'(d), u_i, dn_i);
        push_all(tag);
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mdl[i] = '{0, 1'b0, 1'b0, 1'b0};
    endtask

    initial begin
        reset      = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
        data       = 4'd0;
        count_up   = 1'b1;
        count_down = 1'b0;
        model_reset();

        // Reset state, before any edge and across an edge with up requested.
        #2;
        push_all("reset_pre_edge");
        drain();
        @(posedge clk);
        #1;
        push_all("reset_at_edge");
        drain();
        #3 reset = 1'b1;              // released between edges

        // Ten up pulses from 0 on every instance.
        for (int k = 0; k < 10; k++) begin
            step("up10", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            if (k == 8) chk("a_reaches_9", v_a, 4'd9);
        end
        chk("a_wrap_to_0", v_a, 4'd0);
        chk("a_carry_after_wrap", {3'd0, cy[0]}, 4'd1);
        chk("a_zero_after_wrap", {3'd0, z[0]}, 4'd1);
        chk("b_saturated_at_9", v_b, 4'd9);
        step("carry_drop", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("a_carry_one_cycle", {3'd0, cy[0]}, 4'd0);

        // Clear, then down from 0.
        step("clr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("ovf_cleared", of, 4'd0);
        step("down_from_0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("b_holds_0", v_b, 4'd0);
        chk("b_borrow", {3'd0, bw[1]}, 4'd1);
        chk("a_wraps_to_9", v_a, 4'd9);
        chk("d_wraps_to_15", v_d, 4'd15);
        step("after_borrow", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("b_borrow_one_cycle", {3'd0, bw[1]}, 4'd0);
`ifdef MOD_COUNTER_STICKY_OVF_EN
        chk("b_ovf_sticky", {3'd0, of[1]}, 4'd1);
`else
        chk("b_ovf_tied", {3'd0, of[1]}, 4'd0);
`endif

        // Clamped load, then load+up+clr together.
        step("load13", 1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
        chk("a_load_clamp", v_a, 4'd9);
        chk("a_max", {3'd0, mx[0]}, 4'd1);
        step("clr_load_up", 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        chk("a_clr_wins", v_a, 4'd0);

        // Up and down together at 5 hold the count.
        step("load5", 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("up_and_down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("a_holds_5", v_a, 4'd5);
        chk("no_pulses", cy | bw, 4'd0);

        // Randomised traffic against the model.
        for (int k = 0; k < 60; k++)
            step("random", ($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));

        // Asynchronous reset in the middle of a count.
        step("pre_rst_load", 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        step("pre_rst_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("c_async_reset", {1'b0, v_c}, 4'd0);
        push_all("async_reset_now");
        drain();
        @(posedge clk);
        #1;
        push_all("reset_held_edge");
        drain();
        #3 reset = 1'b1;
        step("first_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("c_first_up", {1'b0, v_c}, 4'd1);
        for (int k = 0; k < 7; k++) step("c_to_wrap", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("c_wrap_0", {1'b0, v_c}, 4'd0);
        chk("c_carry", {3'd0, cy[2]}, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
